// File: rtl/enemy_spawn_sched_pkg.sv
// Shared constants and FSM encoding for the central enemy spawn scheduler.
package enemy_spawn_sched_pkg;
  localparam int SPAWN_NUM_POOLS    = 3;
  localparam int SPAWN_POOL_SIZE    = 8;
  localparam int SPAWN_IDX_W        = 3;
  localparam int SPAWN_RAND_W       = 16;
  localparam int SPAWN_X_W          = 9;
  localparam int SPAWN_X_RANGE      = 400;
  localparam int SPAWN_PERIOD_INIT  = 60;
  localparam int SPAWN_PERIOD_MIN   = 15;
  localparam int SPAWN_PERIOD_STEP  = 5;
  localparam int SPAWN_LEVEL_FRAMES = 600;
  localparam int SPAWN_LEVEL_MAX    = 15;

  typedef logic [1:0] spawn_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARB   = 2'd1;
  localparam logic [1:0] ST_PICK  = 2'd2;
  localparam logic [1:0] ST_ISSUE = 2'd3;
endpackage

// File: rtl/enemy_spawn_sched_if.sv
// Game-side bundle of the spawn scheduler: frame/enable/random inputs and spawn strobes.
interface enemy_spawn_sched_if
  import enemy_spawn_sched_pkg::*;
#(
  parameter int NUM_POOLS = SPAWN_NUM_POOLS,
  parameter int POOL_SIZE = SPAWN_POOL_SIZE,
  parameter int IDX_W     = SPAWN_IDX_W,
  parameter int RAND_W    = SPAWN_RAND_W,
  parameter int X_W       = SPAWN_X_W
);
  logic                           en_i;
  logic                           v_sync_i;
  logic [RAND_W-1:0]              rand_i;
  logic [NUM_POOLS*POOL_SIZE-1:0] free_i;
  logic [NUM_POOLS-1:0]           spawn_o;
  logic [IDX_W-1:0]               spawn_idx_o;
  logic [X_W-1:0]                 spawn_x_o;
  logic [3:0]                     level_o;
  logic                           miss_o;

  modport master (
    output en_i, v_sync_i, rand_i, free_i,
    input  spawn_o, spawn_idx_o, spawn_x_o, level_o, miss_o
  );

  modport slave (
    input  en_i, v_sync_i, rand_i, free_i,
    output spawn_o, spawn_idx_o, spawn_x_o, level_o, miss_o
  );
endinterface

// File: rtl/enemy_spawn_sched_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             any
);
  function automatic logic [PTR_W-1:0] wrap(input int v);
    int r;
    r = v % N;
    return r[PTR_W-1:0];
  endfunction

  // Walk from the farthest candidate back to ptr so the nearest requester wins.
  always_comb begin
    gnt = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[wrap(int'(ptr) + i)]) begin
        gnt = '0;
        gnt[wrap(int'(ptr) + i)] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/enemy_spawn_sched.sv
// Central enemy spawn scheduler: per-period round-robin pool grant, lowest free slot, random X, difficulty ramp.
module enemy_spawn_sched
  import enemy_spawn_sched_pkg::*;
#(
  parameter int NUM_POOLS    = SPAWN_NUM_POOLS,
  parameter int POOL_SIZE    = SPAWN_POOL_SIZE,
  parameter int IDX_W        = SPAWN_IDX_W,
  parameter int RAND_W       = SPAWN_RAND_W,
  parameter int X_W          = SPAWN_X_W,
  parameter int X_RANGE      = SPAWN_X_RANGE,
  parameter int PERIOD_INIT  = SPAWN_PERIOD_INIT,
  parameter int PERIOD_MIN   = SPAWN_PERIOD_MIN,
  parameter int PERIOD_STEP  = SPAWN_PERIOD_STEP,
  parameter int LEVEL_FRAMES = SPAWN_LEVEL_FRAMES
) (
  input  logic                clk_run,
  input  logic                rst,
  enemy_spawn_sched_if.slave  bus
);
  localparam int PTR_W = (NUM_POOLS > 1) ? $clog2(NUM_POOLS) : 1;
  localparam int FC_W  = $clog2(PERIOD_INIT);
  localparam int PER_W = $clog2(PERIOD_INIT + 1);
  localparam int LC_W  = $clog2(LEVEL_FRAMES);

  localparam logic [PER_W-1:0] PER_INIT  = PER_W'(PERIOD_INIT);
  localparam logic [PER_W-1:0] PER_MIN   = PER_W'(PERIOD_MIN);
  localparam logic [PER_W-1:0] PER_STEP  = PER_W'(PERIOD_STEP);
  localparam logic [PER_W-1:0] PER_FLOOR = PER_W'(PERIOD_MIN + PERIOD_STEP);
  localparam logic [LC_W-1:0]  LC_LAST   = LC_W'(LEVEL_FRAMES - 1);
  localparam logic [X_W-1:0]   X_LIM     = X_W'(X_RANGE);
  localparam logic [3:0]       LVL_MAX   = 4'(SPAWN_LEVEL_MAX);

  logic                 vs_d, tick, due_hit, lvl_hit;
  logic [FC_W-1:0]      frame_cnt;
  logic [PER_W-1:0]     period, period_next;
  logic [LC_W-1:0]      lvl_cnt;
  logic [3:0]           level;
  logic                 pending, retry;
  spawn_state_t         state;
  logic [NUM_POOLS-1:0] eligible, arb_gnt, gnt_r, spawn_r;
  logic                 arb_any, miss_r;
  logic [PTR_W-1:0]     rr_ptr;
  logic [POOL_SIZE-1:0] pool_free;
  logic [IDX_W-1:0]     idx_r;
  logic [X_W-1:0]       x_r;
  logic                 unused_rand;

  function automatic logic [IDX_W-1:0] lowest_free(input logic [POOL_SIZE-1:0] f);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = POOL_SIZE - 1; i >= 0; i--)
      if (f[i]) r = IDX_W'(i);
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [NUM_POOLS-1:0] g);
    logic [PTR_W-1:0] r;
    r = '0;
    for (int p = 0; p < NUM_POOLS; p++)
      if (g[p]) r = (p == NUM_POOLS - 1) ? '0 : PTR_W'(p + 1);
    return r;
  endfunction

  // Single conditional subtract is enough because 2^X_W < 2*X_RANGE.
  function automatic logic [X_W-1:0] wrap_x(input logic [X_W-1:0] v);
    return (v >= X_LIM) ? v - X_LIM : v;
  endfunction

  assign tick        = bus.v_sync_i & ~vs_d & bus.en_i;
  assign due_hit     = PER_W'(frame_cnt) >= period - PER_W'(1);
  assign lvl_hit     = lvl_cnt >= LC_LAST;
  assign period_next = (period >= PER_FLOOR) ? period - PER_STEP : PER_MIN;
  assign unused_rand = ^bus.rand_i[RAND_W-1:X_W];

  always_comb begin
    eligible  = '0;
    pool_free = '0;
    for (int p = 0; p < NUM_POOLS; p++) begin
      eligible[p] = |bus.free_i[p*POOL_SIZE +: POOL_SIZE];
      if (gnt_r[p]) pool_free = bus.free_i[p*POOL_SIZE +: POOL_SIZE];
    end
  end

  rr_arbiter #(.N(NUM_POOLS), .PTR_W(PTR_W)) u_arb (
    .req (eligible),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .any (arb_any)
  );

  // Frame tick, spawn period and difficulty counters
  always_ff @(posedge clk_run) begin
    if (rst) begin
      vs_d      <= 1'b0;
      frame_cnt <= '0;
      lvl_cnt   <= '0;
      period    <= PER_INIT;
      level     <= '0;
    end else begin
      vs_d <= bus.v_sync_i;
      if (tick) begin
        frame_cnt <= due_hit ? '0 : frame_cnt + 1'b1;
        if (lvl_hit) begin
          lvl_cnt <= '0;
          period  <= period_next;
          if (level != LVL_MAX) level <= level + 4'd1;
        end else begin
          lvl_cnt <= lvl_cnt + 1'b1;
        end
      end
    end
  end

  // Arbitration FSM; a held pending spawn is only retried on a later tick
  always_ff @(posedge clk_run) begin
    if (rst) begin
      state   <= ST_IDLE;
      pending <= 1'b0;
      retry   <= 1'b0;
      gnt_r   <= '0;
      rr_ptr  <= '0;
      spawn_r <= '0;
      idx_r   <= '0;
      x_r     <= '0;
      miss_r  <= 1'b0;
    end else begin
      spawn_r <= '0;
      miss_r  <= 1'b0;
      if (bus.en_i) begin
        case (state)
          ST_IDLE: if (pending && retry) begin
            retry <= 1'b0;
            state <= ST_ARB;
          end
          ST_ARB: if (arb_any) begin
            gnt_r  <= arb_gnt;
            rr_ptr <= next_ptr(arb_gnt);
            state  <= ST_PICK;
          end else begin
            miss_r <= 1'b1;
            state  <= ST_IDLE;
          end
          ST_PICK: if (|pool_free) begin
            idx_r   <= lowest_free(pool_free);
            x_r     <= wrap_x(bus.rand_i[X_W-1:0]);
            spawn_r <= gnt_r;
            state   <= ST_ISSUE;
          end else begin
            state <= ST_IDLE;
          end
          default: begin
            pending <= 1'b0;
            state   <= ST_IDLE;
          end
        endcase
      end
      if (tick && (due_hit || pending)) retry <= 1'b1;
      if (tick && due_hit) pending <= 1'b1;
    end
  end

  assign bus.spawn_o     = spawn_r;
  assign bus.spawn_idx_o = idx_r;
  assign bus.spawn_x_o   = x_r;
  assign bus.level_o     = level;
  assign bus.miss_o      = miss_r;
endmodule

// File: tb/tb_enemy_spawn_sched.sv
// Bench for enemy_spawn_sched: directed vector table, hand sequences, then random frames against a frame-level model.
module tb_enemy_spawn_sched;
  import enemy_spawn_sched_pkg::*;

  logic clk_run = 1'b0;
  logic rst;
  always #5 clk_run = ~clk_run;

  enemy_spawn_sched_if bus ();

  enemy_spawn_sched dut (
    .clk_run (clk_run),
    .rst     (rst),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          en;
    int          n;
    logic [23:0] fr;
    logic [15:0] rn;
    int          sp;
    int          ix;
    int          x;
    int          ms;
  } vec_t;
  vec_t tbl[11];

  // frame-level reference model state
  int m_since, m_frames, m_per, m_lvl, m_rr;
  bit m_pend;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  function automatic int enc(input int n, input int k, input int v, input int want_k);
    if (n == 0) return 0;
    if (n == 1 && k == want_k) return v;
    return -1;
  endfunction

  task automatic model_reset();
    m_since = 0; m_frames = 0; m_per = 60; m_lvl = 0; m_rr = 0; m_pend = 0;
  endtask

  task automatic model_tick(input bit en, input logic [23:0] fr, input logic [15:0] rn,
                            output int e_sp, output int e_ix, output int e_x, output int e_ms);
    logic [7:0] b;
    bit done;
    e_sp = 0; e_ix = 0; e_x = 0; e_ms = 0;
    if (en) begin
      m_since++;
      if (m_since >= m_per) begin
        m_since = 0;
        m_pend  = 1;
      end
      m_frames++;
      if (m_frames % 600 == 0) begin
        m_lvl = (m_lvl < 15) ? m_lvl + 1 : 15;
        m_per = (m_per - 5 < 15) ? 15 : m_per - 5;
      end
      if (m_pend) begin
        done = 0;
        for (int i = 0; i < 3; i++) begin
          int p;
          p = (m_rr + i) % 3;
          b = fr[p*8 +: 8];
          if (!done && b != 0) begin
            done = 1;
            e_sp = 1 << p;
            for (int s = 7; s >= 0; s--) if (b[s]) e_ix = s;
            e_x = int'(rn) % 512;
            if (e_x >= 400) e_x -= 400;
            m_rr = (p + 1) % 3;
            m_pend = 0;
          end
        end
        if (!done) e_ms = 1;
      end
    end
  endtask

  // One frame: v_sync high for one cycle, then five samples k=0..4 after successive edges.
  task automatic do_tick(input bit en, input logic [23:0] fr, input logic [15:0] rn,
                         output int sp, output int sp_k, output int sp_n, output int ix,
                         output int xx, output int ms_k, output int ms_n);
    @(negedge clk_run);
    bus.en_i = en; bus.free_i = fr; bus.rand_i = rn; bus.v_sync_i = 1'b1;
    sp = 0; sp_k = -1; sp_n = 0; ix = 0; xx = 0; ms_k = -1; ms_n = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_run);
      if (k == 0) bus.v_sync_i = 1'b0;
      if (bus.spawn_o != 0) begin
        sp_n++; sp_k = k; sp = int'(bus.spawn_o);
        ix = int'(bus.spawn_idx_o); xx = int'(bus.spawn_x_o);
      end
      if (bus.miss_o) begin ms_n++; ms_k = k; end
    end
  endtask

  task automatic run_quiet(input string name, input int n, input bit en,
                           input logic [23:0] fr, input logic [15:0] rn);
    int bad, sp, spk, spn, ix, xx, msk, msn;
    bad = 0;
    for (int j = 0; j < n; j++) begin
      do_tick(en, fr, rn, sp, spk, spn, ix, xx, msk, msn);
      if (spn != 0 || msn != 0) bad++;
    end
    check(name, bad, 0);
  endtask

  initial begin
    int sp, spk, spn, ix, xx, msk, msn;
    int e_sp, e_ix, e_x, e_ms;
    int en_frames, frames, bad;
    logic [23:0] fr;

    rst = 1'b1;
    bus.en_i = 1'b0; bus.v_sync_i = 1'b0; bus.rand_i = '0; bus.free_i = '0;
    repeat (3) @(negedge clk_run);
    check("rst_spawn", int'(bus.spawn_o), 0);
    check("rst_idx", int'(bus.spawn_idx_o), 0);
    check("rst_x", int'(bus.spawn_x_o), 0);
    check("rst_level", int'(bus.level_o), 0);
    check("rst_miss", int'(bus.miss_o), 0);
    rst = 1'b0;

    tbl[0]  = '{1'b1, 60,  24'hFFFFFF, 16'd0,    1, 0, 0,   0};
    tbl[1]  = '{1'b1, 60,  24'hFFFFFF, 16'd0,    2, 0, 0,   0};
    tbl[2]  = '{1'b1, 60,  24'hFFFFFF, 16'd0,    4, 0, 0,   0};
    tbl[3]  = '{1'b1, 60,  24'hFFFFF0, 16'd450,  1, 4, 50,  0};
    tbl[4]  = '{1'b1, 60,  24'h000000, 16'h1234, 0, 0, 0,   1};
    tbl[5]  = '{1'b1, 1,   24'h000400, 16'd399,  2, 2, 399, 0};
    tbl[6]  = '{1'b1, 59,  24'h000080, 16'd511,  1, 7, 111, 0};
    tbl[7]  = '{1'b1, 60,  24'h020000, 16'hFF90, 4, 1, 0,   0};
    tbl[8]  = '{1'b1, 30,  24'hFFFFFF, 16'd0,    0, 0, 0,   0};
    tbl[9]  = '{1'b0, 100, 24'hFFFFFF, 16'd0,    0, 0, 0,   0};
    tbl[10] = '{1'b1, 30,  24'hFFFFFF, 16'd5,    1, 0, 5,   0};

    for (int t = 0; t < 11; t++) begin
      if (tbl[t].n > 1)
        run_quiet($sformatf("vec%0d_quiet", t), tbl[t].n - 1, tbl[t].en, tbl[t].fr, tbl[t].rn);
      do_tick(tbl[t].en, tbl[t].fr, tbl[t].rn, sp, spk, spn, ix, xx, msk, msn);
      check($sformatf("vec%0d_spawn", t), enc(spn, spk, sp, 3), tbl[t].sp);
      if (tbl[t].sp != 0) begin
        check($sformatf("vec%0d_idx", t), ix, tbl[t].ix);
        check($sformatf("vec%0d_x", t), xx, tbl[t].x);
      end
      check($sformatf("vec%0d_miss", t), enc(msn, msk, 1, 2), tbl[t].ms);
    end

    // en_i dropped while the FSM sits in ARB: spawn slips by the 5 frozen cycles
    run_quiet("hold_quiet", 59, 1'b1, 24'hFFFFFF, 16'd123);
    @(negedge clk_run);
    bus.en_i = 1'b1; bus.v_sync_i = 1'b1;
    sp = 0; spk = -1; spn = 0; msn = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk_run);
      if (k == 0) bus.v_sync_i = 1'b0;
      if (bus.spawn_o != 0) begin
        spn++; spk = k; sp = int'(bus.spawn_o);
        ix = int'(bus.spawn_idx_o); xx = int'(bus.spawn_x_o);
      end
      if (bus.miss_o) msn++;
      if (k == 1) bus.en_i = 1'b0;
      if (k == 6) bus.en_i = 1'b1;
    end
    check("hold_spawn", enc(spn, spk, sp, 8), 2);
    check("hold_idx", ix, 0);
    check("hold_x", xx, 123);
    check("hold_miss", msn, 0);

    // reset while the FSM is in PICK on the 600th frame
    run_quiet("rstpick_quiet", 59, 1'b1, 24'hFFFFFF, 16'd77);
    @(negedge clk_run);
    bus.v_sync_i = 1'b1;
    @(negedge clk_run);
    bus.v_sync_i = 1'b0;
    @(negedge clk_run);
    check("level_up", int'(bus.level_o), 1);
    @(negedge clk_run);
    rst = 1'b1;
    @(negedge clk_run);
    rst = 1'b0;
    check("rstpick_spawn", int'(bus.spawn_o), 0);
    check("rstpick_idx", int'(bus.spawn_idx_o), 0);
    check("rstpick_x", int'(bus.spawn_x_o), 0);
    check("rstpick_level", int'(bus.level_o), 0);
    check("rstpick_miss", int'(bus.miss_o), 0);
    @(negedge clk_run);
    check("rstpick_noissue", int'(bus.spawn_o), 0);
    run_quiet("rstpick_restart_quiet", 59, 1'b1, 24'hFFFFFF, 16'd77);
    do_tick(1'b1, 24'hFFFFFF, 16'd77, sp, spk, spn, ix, xx, msk, msn);
    check("rstpick_restart_spawn", enc(spn, spk, sp, 3), 1);
    check("rstpick_restart_x", xx, 77);

    // random frames against the model, long enough to saturate the level
    @(negedge clk_run);
    rst = 1'b1; bus.v_sync_i = 1'b0;
    repeat (2) @(negedge clk_run);
    rst = 1'b0;
    model_reset();
    en_frames = 0; frames = 0; bad = 0;
    while (en_frames < 9150 && frames < 12000) begin
      bit en;
      logic [15:0] rn;
      en = ($urandom_range(0, 31) != 0);
      rn = 16'($urandom);
      fr = 24'($urandom);
      for (int p = 0; p < 3; p++)
        if ($urandom_range(0, 3) == 0) fr[p*8 +: 8] = 8'h00;
      if ($urandom_range(0, 7) == 0) fr = '0;
      model_tick(en, fr, rn, e_sp, e_ix, e_x, e_ms);
      do_tick(en, fr, rn, sp, spk, spn, ix, xx, msk, msn);
      check("rnd_spawn", enc(spn, spk, sp, 3), e_sp);
      if (e_sp != 0) begin
        check("rnd_idx", ix, e_ix);
        check("rnd_x", xx, e_x);
      end
      check("rnd_miss", enc(msn, msk, 1, 2), e_ms);
      check("rnd_level", int'(bus.level_o), m_lvl);
      if (en) en_frames++;
      frames++;
    end
    check("level_saturated", int'(bus.level_o), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
